queue_fifo: RTL and testbench

QUEUE_FIFO -- requirements
Module: queue_fifo

---
 rtl/queue_fifo.sv | 107 ++++++++++
 tb/tb_queue_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_fifo.sv
// Synchronous FIFO with registered read data, full/empty flags and an overflow/underflow error flag.
// Optional occupancy output `count` is present only when FIFO_COUNT_EN is defined.
module queue_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  error,
    output logic                  mem_full,
    output logic                  mem_empty
`ifdef FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   count
`endif
);

    localparam logic [ADDR_WIDTH:0]   OCC_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   OCC_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  error_q, error_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  do_write;
    logic                  do_read;

    always_comb begin
        // A push into a full queue still lands when a pop frees the slot in the same edge.
        do_write   = push && (!full_q || pop);
        do_read    = pop && !empty_q;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        data_out_d = data_out_q;
        error_d    = error_q;

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_read) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem[rd_ptr_q];
        end

        case ({do_write, do_read})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        if (push || pop) begin
            error_d = (push && !pop && full_q) || (pop && empty_q);
        end

        full_d  = (occ_d == OCC_FULL);
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            data_out_q <= '0;
            error_q    <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable through the pointers.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign error     = error_q;
    assign mem_full  = full_q;
    assign mem_empty = empty_q;
`ifdef FIFO_COUNT_EN
    assign count     = occ_q;
`endif

endmodule

// File: tb/tb_queue_fifo.sv
// Self-checking bench for queue_fifo: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model. Checks count under FIFO_COUNT_EN.
module tb_queue_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          push    = 1'b0;
    logic          pop     = 1'b0;
    logic [DW-1:0] data_out;
    logic          error;
    logic          mem_full;
    logic          mem_empty;
`ifdef FIFO_COUNT_EN
    logic [AW:0]   count;
`endif

    queue_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .push      (push),
        .pop       (pop),
        .data_out  (data_out),
        .error     (error),
        .mem_full  (mem_full),
        .mem_empty (mem_empty)
`ifdef FIFO_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: contents as a plain queue plus the last read word and error flag.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_err  = 1'b0;

    typedef struct {
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          err;
        logic          full;
        logic          empty;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic p, input logic r, input logic [DW-1:0] d);
        if (p && r) begin
            if (mq.size() == 0) begin
                mq.push_back(d);
                m_err = 1'b1;
            end else begin
                m_dout = mq.pop_front();
                mq.push_back(d);
                m_err = 1'b0;
            end
        end else if (p) begin
            if (mq.size() == DEPTH) m_err = 1'b1;
            else begin
                mq.push_back(d);
                m_err = 1'b0;
            end
        end else if (r) begin
            if (mq.size() == 0) m_err = 1'b1;
            else begin
                m_dout = mq.pop_front();
                m_err = 1'b0;
            end
        end
    endtask

    task automatic step(input logic p, input logic r, input logic [DW-1:0] d);
        @(negedge clock);
        push    = p;
        pop     = r;
        data_in = d;
        @(posedge clock);
        #1;
        model_step(p, r, d);
        $display("[TB] t=%0t push=%0b pop=%0b din=%02h -> dout=%02h err=%0b full=%0b empty=%0b",
                 $time, p, r, d, data_out, error, mem_full, mem_empty);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".dout"},  32'(data_out),  32'(m_dout));
        chk({tag, ".err"},   32'(error),     32'(m_err));
        chk({tag, ".full"},  32'(mem_full),  32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(mem_empty), 32'(mq.size() == 0));
`ifdef FIFO_COUNT_EN
        chk({tag, ".count"}, 32'(count),     32'(mq.size()));
`endif
    endtask

    task automatic chk_count(input string name, input int exp);
`ifdef FIFO_COUNT_EN
        chk(name, 32'(count), 32'(exp));
`else
        if (exp == 0) chk({name, ".empty"}, 32'(mem_empty), 32'd1);
        else if (exp == DEPTH) chk({name, ".full"}, 32'(mem_full), 32'd1);
        else chk({name, ".mid"}, 32'({mem_full, mem_empty}), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1};

        // Power-on reset values, held across a couple of edges.
        #12;
        chk("por.empty", 32'(mem_empty), 32'd1);
        chk("por.full",  32'(mem_full),  32'd0);
        chk("por.err",   32'(error),     32'd0);
        chk("por.dout",  32'(data_out),  32'd0);
        chk_count("por.count", 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Ordering, underflow and recovery vectors.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].din);
            chk($sformatf("vec%0d.dout", i),  32'(data_out),  32'(tbl[i].dout));
            chk($sformatf("vec%0d.err", i),   32'(error),     32'(tbl[i].err));
            chk($sformatf("vec%0d.full", i),  32'(mem_full),  32'(tbl[i].full));
            chk($sformatf("vec%0d.empty", i), 32'(mem_empty), 32'(tbl[i].empty));
        end

        // Overflow: ninth push rejected, only the first eight come back.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        chk("ovf.full8", 32'(mem_full), 32'd1);
        chk("ovf.err8",  32'(error),    32'd0);
        step(1'b1, 1'b0, 8'hFF);
        chk("ovf.err9",  32'(error),    32'd1);
        chk("ovf.full9", 32'(mem_full), 32'd1);
        chk_count("ovf.count9", DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("ovf.pop%0d", i), 32'(data_out), 32'(8'h40 + i));
        end
        chk("ovf.empty", 32'(mem_empty), 32'd1);

        // Simultaneous push+pop while full, then while empty.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        step(1'b1, 1'b1, 8'hA5);
        chk("pp_full.dout", 32'(data_out), 32'h80);
        chk("pp_full.err",  32'(error),    32'd0);
        chk("pp_full.full", 32'(mem_full), 32'd1);
        chk_count("pp_full.count", DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("pp_drain%0d", i), 32'(data_out), (i == DEPTH) ? 32'hA5 : 32'(8'h80 + i));
        end
        step(1'b1, 1'b1, 8'h3C);
        chk("pp_empty.err",   32'(error),     32'd1);
        chk("pp_empty.empty", 32'(mem_empty), 32'd0);
        chk("pp_empty.dout",  32'(data_out),  32'hA5);
        chk_count("pp_empty.count", 1);
        step(1'b0, 1'b1, 8'h00);
        chk("pp_empty.next", 32'(data_out), 32'h3C);
        chk("pp_empty.err2", 32'(error),    32'd0);

        // Wrap-around: three fill/drain rounds move both pointers past DEPTH several times.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
                chk_model($sformatf("wrap%0d.fill%0d", r, i));
            end
            for (int i = 0; i < DEPTH; i++) begin
                step(1'b0, 1'b1, 8'h00);
                chk_model($sformatf("wrap%0d.drain%0d", r, i));
            end
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            chk_model($sformatf("rnd%0d", i));
        end

        // Mid-stream asynchronous reset with nonzero data_out and error set.
        for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        chk_model("pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst.empty", 32'(mem_empty), 32'd1);
        chk("rst.full",  32'(mem_full),  32'd0);
        chk("rst.err",   32'(error),     32'd0);
        chk("rst.dout",  32'(data_out),  32'd0);
        chk_count("rst.count", 0);
        push = 1'b1;
        pop  = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_hold.empty", 32'(mem_empty), 32'd1);
        @(negedge clock);
        push = 1'b0;
        pop  = 1'b0;
        reset_n = 1'b1;
        mq.delete();
        m_dout = '0;
        m_err  = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        chk_model("post_rst.pop");
        step(1'b1, 1'b0, 8'h9C);
        chk_model("post_rst.push");
        step(1'b0, 1'b1, 8'h00);
        chk_model("post_rst.pop2");
        chk("post_rst.dout", 32'(data_out), 32'h9C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
